// File: rtl/alarm_timer_pkg.sv
// Shared definitions for the alarm timer: interval encodings, default
// period lengths in seconds and the timer state type.
package alarm_timer_pkg;

    localparam logic [1:0] INT_ARM       = 2'b00;
    localparam logic [1:0] INT_DRIVER    = 2'b01;
    localparam logic [1:0] INT_PASSENGER = 2'b10;
    localparam logic [1:0] INT_ALARM     = 2'b11;

    localparam logic [3:0] DEF_ARM       = 4'd6;
    localparam logic [3:0] DEF_DRIVER    = 4'd8;
    localparam logic [3:0] DEF_PASSENGER = 4'd15;
    localparam logic [3:0] DEF_ALARM     = 4'd10;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_DONE  = 2'd2
    } timer_state_t;

    // Power-up / reset period for a given interval selector.
    function automatic logic [3:0] default_period(input logic [1:0] sel);
        logic [3:0] val;
        val = DEF_ARM;
        case (sel)
            INT_ARM:       val = DEF_ARM;
            INT_DRIVER:    val = DEF_DRIVER;
            INT_PASSENGER: val = DEF_PASSENGER;
            INT_ALARM:     val = DEF_ALARM;
            default:       val = DEF_ARM;
        endcase
        return val;
    endfunction

endpackage

// File: rtl/alarm_timer_one_hz_divider.sv
// one_hz_divider: free-running prescaler counting 0..CLK_FREQ-1.
// tick is high while the count sits on its last value; restart forces the
// count back to 0 so the next wrap is a full CLK_FREQ cycles away.
module one_hz_divider #(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic restart,
    output logic tick
);
    localparam int CW = (CLK_FREQ > 2) ? $clog2(CLK_FREQ) : 1;
    localparam logic [CW-1:0] LAST = CW'(CLK_FREQ - 1);

    logic [CW-1:0] r_cnt;

    // Prescaler count: wraps at LAST, restarts on request.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_cnt <= '0;
        end else if (restart || (r_cnt == LAST)) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + CW'(1);
        end
    end

    assign tick = (r_cnt == LAST);

endmodule

// File: rtl/alarm_timer.sv
// alarm_timer: seconds countdown for the vehicle alarm FSM.
// Optional feature macro ALARM_TIMER_REPROG_EN: when defined the four
// period parameters are writable registers; otherwise they are constants
// and the reprogram inputs are ignored.
module alarm_timer
    import alarm_timer_pkg::*;
#(
    parameter int CLK_FREQ = 50_000_000
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       start_timer,
    input  logic [1:0] interval,
    input  logic       reprogram,
    input  logic [1:0] time_param_sel,
    input  logic [3:0] time_value,
    output logic       expired,
    output logic       one_hz_enable,
    output logic [3:0] time_left
);
    timer_state_t r_state;
    logic [3:0]   r_time_left;
    logic         r_expired;
    logic         r_one_hz;
    logic [1:0]   r_int_lat;
    logic [3:0]   w_load_val;
    logic         w_load;
    logic         w_wrap;

`ifdef ALARM_TIMER_REPROG_EN
    logic [3:0] r_param [4];

    // Period parameters: reset to defaults, rewritten by a reprogram pulse.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 4; i++) begin
                r_param[i] <= default_period(2'(i));
            end
        end else if (reprogram) begin
            r_param[time_param_sel] <= time_value;
        end
    end

    // Loads read the pre-update value, so a same-edge reprogram is not seen.
    assign w_load_val = r_param[interval];
`else
    logic w_unused_reprog;
    assign w_unused_reprog = ^{reprogram, time_param_sel, time_value};
    assign w_load_val      = default_period(interval);
`endif

    // A load happens when leaving IDLE, or on an interval handover while running.
    assign w_load = start_timer && ((r_state == ST_IDLE) || (r_int_lat != interval));

    one_hz_divider #(
        .CLK_FREQ(CLK_FREQ)
    ) u_divider (
        .clock  (clock),
        .reset  (reset),
        .restart(w_load),
        .tick   (w_wrap)
    );

    // Registered one-second strobe; a wrap coinciding with a load is dropped.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_one_hz <= 1'b0;
        end else begin
            r_one_hz <= w_wrap && !w_load;
        end
    end

    // Timer FSM: start_timer low wins, then loads, then the countdown.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state     <= ST_IDLE;
            r_time_left <= 4'd0;
            r_expired   <= 1'b0;
            r_int_lat   <= INT_ARM;
        end else begin
            r_expired <= 1'b0;
            if (!start_timer) begin
                r_state     <= ST_IDLE;
                r_time_left <= 4'd0;
            end else if (w_load) begin
                r_state     <= ST_COUNT;
                r_time_left <= w_load_val;
                r_int_lat   <= interval;
            end else begin
                case (r_state)
                    ST_COUNT: begin
                        // A zero-length period finishes without waiting for a tick.
                        if ((r_time_left == 4'd0) || (w_wrap && (r_time_left == 4'd1))) begin
                            r_time_left <= 4'd0;
                            r_expired   <= 1'b1;
                            r_state     <= ST_DONE;
                        end else if (w_wrap) begin
                            r_time_left <= r_time_left - 4'd1;
                        end
                    end
                    default: begin
                        r_state <= r_state;
                    end
                endcase
            end
        end
    end

    assign expired       = r_expired;
    assign one_hz_enable = r_one_hz;
    assign time_left     = r_time_left;

endmodule

// File: tb/tb_alarm_timer.sv
// Testbench for alarm_timer with CLK_FREQ = 4. A timeline-based reference
// model (elapsed cycles since the last load / prescaler restart) predicts
// every output after every clock edge; directed scenarios add latency checks.
module tb_alarm_timer;
    localparam int F = 4;

    logic       clock = 1'b0;
    logic       reset;
    logic       start_timer;
    logic [1:0] interval;
    logic       reprogram;
    logic [1:0] time_param_sel;
    logic [3:0] time_value;
    logic       expired;
    logic       one_hz_enable;
    logic [3:0] time_left;

    alarm_timer #(.CLK_FREQ(F)) dut (
        .clock         (clock),
        .reset         (reset),
        .start_timer   (start_timer),
        .interval      (interval),
        .reprogram     (reprogram),
        .time_param_sel(time_param_sel),
        .time_value    (time_value),
        .expired       (expired),
        .one_hz_enable (one_hz_enable),
        .time_left     (time_left)
    );

    always #5 clock = ~clock;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state
    int         n;        // clock edges since time zero of the model
    int         ref_e;    // edge at which the prescaler was last at 0
    int         load_e;   // edge of the last load
    int         period;   // seconds loaded at last load
    int         mode;     // 0 idle, 1 counting, 2 done
    logic [1:0] lat;
    int         m_tl;
    int         m_exp;
    int         m_hz;
    int         m_param [4];
    int         dut_exp_cnt;
    int         dut_last_exp;

    task automatic chk(input string tag, input int got, input int exp);
        n_checks++;
        if (got != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d (edge %0d)", tag, got, exp, n);
        end
    endtask

    task automatic model_defaults();
        m_param[0] = 6;
        m_param[1] = 8;
        m_param[2] = 15;
        m_param[3] = 10;
    endtask

    task automatic step();
        int el;
        @(posedge clock);
        n++;
        m_exp = 0;
        if (!start_timer) begin
            mode = 0;
            m_tl = 0;
        end else if (mode == 0 || interval != lat) begin
            period = m_param[interval];
            load_e = n;
            ref_e  = n;
            lat    = interval;
            mode   = 1;
            m_tl   = period;
        end else if (mode == 1) begin
            el = n - load_e;
            if (period == 0) begin
                mode  = 2;
                m_exp = 1;
            end else begin
                m_tl = period - el / F;
                if (m_tl == 0) begin
                    m_exp = 1;
                    mode  = 2;
                end
            end
        end
        m_hz = ((n > ref_e) && ((n - ref_e) % F == 0)) ? 1 : 0;
`ifdef ALARM_TIMER_REPROG_EN
        if (reprogram) m_param[time_param_sel] = int'(time_value);
`endif
        #1;
        if (expired) begin
            dut_exp_cnt++;
            dut_last_exp = n;
        end
        chk("expired", int'(expired), m_exp);
        chk("one_hz_enable", int'(one_hz_enable), m_hz);
        chk("time_left", int'(time_left), m_tl);
    endtask

    task automatic run(input int k);
        for (int i = 0; i < k; i++) step();
    endtask

    task automatic do_reset();
        #3;
        reset = 1'b0;
        #1;
        chk("rst_expired", int'(expired), 0);
        chk("rst_one_hz", int'(one_hz_enable), 0);
        chk("rst_time_left", int'(time_left), 0);
        mode = 0;
        m_tl = 0;
        model_defaults();
        @(posedge clock);
        @(posedge clock);
        @(negedge clock);
        reset = 1'b1;
        ref_e = n;
    endtask

    initial begin
        int L;
        int c0;
        reset          = 1'b0;
        start_timer    = 1'b0;
        interval       = 2'b00;
        reprogram      = 1'b0;
        time_param_sel = 2'b00;
        time_value     = 4'd0;
        n = 0; ref_e = 0; load_e = 0; period = 0; mode = 0; lat = 2'b00;
        m_tl = 0; m_exp = 0; m_hz = 0;
        dut_exp_cnt = 0; dut_last_exp = -1;
        model_defaults();

        #2;
        chk("por_expired", int'(expired), 0);
        chk("por_one_hz", int'(one_hz_enable), 0);
        chk("por_time_left", int'(time_left), 0);
        #10;
        reset = 1'b1;

        // Idle with prescaler running
        run(6);

        // Arm delay with defaults: one expiry 24 cycles after load
        start_timer = 1'b1; interval = 2'b00;
        c0 = dut_exp_cnt;
        step(); L = load_e;
        run(29);
        chk("arm_once", dut_exp_cnt - c0, 1);
        chk("arm_latency", dut_last_exp - L, 24);

        // Driver delay held 10 s, then handover to alarm-on
        start_timer = 1'b0; step();
        start_timer = 1'b1; interval = 2'b01;
        step();
        run(39);
        interval = 2'b11;
        step(); L = load_e;
        chk("handover_tl", int'(time_left), 10);
        run(44);
        chk("alarm_latency", dut_last_exp - L, 40);

        // Drop start_timer one cycle before the final tick
        start_timer = 1'b0; step();
        start_timer = 1'b1; interval = 2'b00;
        c0 = dut_exp_cnt;
        step(); L = load_e;
        run(22);
        start_timer = 1'b0;
        step();
        chk("abort_tl", int'(time_left), 0);
        run(4);
        chk("abort_no_exp", dut_exp_cnt - c0, 0);

        // Reprogram passenger during an arm count
        start_timer = 1'b1; interval = 2'b00;
        step(); L = load_e;
        run(5);
        reprogram = 1'b1; time_param_sel = 2'b10; time_value = 4'd3;
        step();
        reprogram = 1'b0;
        run(25);
        chk("arm_unaffected", dut_last_exp - L, 24);
        interval = 2'b10;
        step(); L = load_e;
        run(64);
`ifdef ALARM_TIMER_REPROG_EN
        chk("pass_latency", dut_last_exp - L, 12);
`else
        chk("pass_latency", dut_last_exp - L, 60);
`endif

        // Zero-length arm period
        start_timer = 1'b0;
        reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd0;
        step();
        reprogram = 1'b0;
        start_timer = 1'b1; interval = 2'b00;
        step(); L = load_e;
        run(28);
`ifdef ALARM_TIMER_REPROG_EN
        chk("zero_latency", dut_last_exp - L, 1);
`else
        chk("zero_latency", dut_last_exp - L, 24);
`endif

        // Reset mid-count
        start_timer = 1'b0; step();
        reprogram = 1'b1; time_param_sel = 2'b00; time_value = 4'd2;
        step();
        reprogram = 1'b0;
        start_timer = 1'b1; interval = 2'b00;
        step();
        run(5);
        start_timer = 1'b0;
        c0 = dut_exp_cnt;
        do_reset();
        run(30);
        chk("post_reset_no_exp", dut_exp_cnt - c0, 0);
        start_timer = 1'b1; interval = 2'b00;
        step(); L = load_e;
        run(28);
        chk("post_reset_default", dut_last_exp - L, 24);

        // Randomized traffic
        for (int i = 0; i < 1500; i++) begin
            start_timer = ($urandom_range(0, 29) != 0);
            if ($urandom_range(0, 49) == 0) interval = 2'($urandom_range(0, 3));
            reprogram = ($urandom_range(0, 14) == 0);
            time_param_sel = 2'($urandom_range(0, 3));
            time_value = 4'($urandom_range(0, 15));
            step();
        end
        reprogram = 1'b0;

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
